fixed_att_input_fork: RTL and testbench
=======================================

# fixed_att_input_fork

Registered three-way broadcast buffer that sits directly upstream of the fixed-point self-attention block and replicates one input-block stream onto the Q, K and V data inputs. Each of the three branches handshakes independently, so a stalled projection does not stall the others until the buffer fills. `data_in_ready` depends only on registered state, never combinationally on a downstream ready. This removes the combinational valid/ready coupling between the three projection consumers.

## Interface

Reset is fixed: one clock; reset is asynchronous and active-low.

Parameters:

- `DATA_WIDTH`, default 8: element width in bits.
- `IN_PARALLELISM`, default 3: rows per transferred block.
- `IN_SIZE`, default 3: columns per transferred block. A word is `IN_PARALLELISM*IN_SIZE` elements.
- `DEPTH`, default 2: buffer entries. Must be a power of two and at least 2.

Ports:

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `data_in`, input, `[DATA_WIDTH-1:0] x IN_PARALLELISM*IN_SIZE`: input block.
- `data_in_valid`, input, 1: upstream valid.
- `data_in_ready`, output, 1: buffer can accept a word.
- `data_out_q`, `data_out_k`, `data_out_v`, output, same shape as `data_in`: per-branch head word.
- `data_out_q_valid`, `data_out_k_valid`, `data_out_v_valid`, output, 1: branch has an unread word.
- `data_out_q_ready`, `data_out_k_ready`, `data_out_v_ready`, input, 1: branch consumer accepts.

## Operation

- Storage `mem[DEPTH]` holds words. It is not reset.
- The write pointer `wp` and the per-branch read pointers `rp_q`, `rp_k`, `rp_v` are each `PTR_W+1` bits, where `PTR_W = $clog2(DEPTH)`. The MSB is the wrap bit.
- Push: on `data_in_valid && data_in_ready`, write `mem[wp[PTR_W-1:0]] <= data_in` and set `wp <= wp+1`.
- Branch x:
  - `data_out_x_valid = (wp != rp_x)`.
  - `data_out_x = mem[rp_x[PTR_W-1:0]]`.
  - Pop: on `valid_x && ready_x`, set `rp_x <= rp_x+1`.
- Per-branch occupancy: `occ_x = wp - rp_x`, computed modulo `2^(PTR_W+1)`.
- Buffer occupancy: `used = max(occ_q, occ_k, occ_v)`.
- Ready: `data_in_ready = (used < DEPTH) && rst`.
  - It is computed from registered pointers only.
  - A pop in the same cycle does not free a slot for a push in that cycle.
- An entry is freed only when all three branches have read it.
- Word order is preserved per branch. Every word is delivered exactly once on each branch.
- Simultaneous push and pops in one cycle are all applied; the pointers update independently.
- Wrap-around: pointers wrap modulo `2^(PTR_W+1)`. The full condition `used == DEPTH` and the empty condition `occ_x == 0` remain distinct through wrap.
- Reset asserted (`rst` = 0):
  - All pointers are cleared to 0 asynchronously.
  - All `*_valid` outputs are 0.
  - `data_in_ready` is 0.
  - `data_out_*` values are don't-care whenever the matching valid is 0.
- Reset mid-operation discards all outstanding words. No stale word is re-emitted after reset releases.
- There is no arithmetic on data. Width is pass-through, bit-exact.

## Timing

- Latency: a word accepted at edge N is visible with valid high on all three branches after edge N. A consumer can take it at edge N+1.
- Throughput: one word per cycle when all branches are ready. `DEPTH` = 2 is sufficient for full rate.
- Skew: one branch may lag the fastest by up to `DEPTH` words before `data_in_ready` drops.
- Full to not-full: after a pop that frees the last slot at edge M, `data_in_ready` rises after edge M.
- First cycle after reset release: `data_in_ready` = 1 and all valids = 0.
- Handshake rules:
  - `data_out_x_valid` never drops without a pop.
  - The head data of a branch is stable while its valid is high and it has not been popped.

## Structure

- Shared package `attention_pkg` holds:
  - the `PTR_W` helper, expressed as a function wrapping `$clog2`;
  - a common occupancy/max helper function, reusable by other attention-stage buffers.
- One sub-module, `fixed_att_fork_branch`, instantiated three times. It contains the read pointer register, the valid compare, the pop logic and the occupancy output, with `wp` as an input.
- The top level holds `mem`, `wp`, the max-occupancy logic and ready generation.

## Test plan

- Reset: hold `rst` = 0 with `data_in_valid` = 1 -> `data_in_ready` = 0 and all valids = 0. On release, `data_in_ready` = 1 the next cycle.
- Single word `0x11` in all elements, with only the q consumer ready -> `data_out_q` = `0x11` consumed at the cycle after the push. k and v keep `0x11` with valid high. `data_in_ready` stays 1.
- Back-pressure: all branch readies = 0, push `0xA0`, `0xA1` -> `data_in_ready` = 0 after the second push and a third word `0xA2` is held upstream.
  - Raise q and k ready -> still full.
  - Raise v ready -> `data_in_ready` = 1 one cycle after v pops `0xA0`.
- Streaming: all readies = 1, push words 0..15 back-to-back -> each branch emits 0..15 in order, one per cycle, one cycle after each push, with no bubbles.
- Skew and wrap: 100 words, k ready random at 1 in 3, q and v always ready -> each branch sees exactly words 0..99 in order. No branch ever has more than `DEPTH` words outstanding. Pointers wrap several times.
- Reset mid-operation with 2 words outstanding on v -> all valids are 0 after reset. After release, pushing `0x55` yields only `0x55` on every branch.

Source files
------------

// File: rtl/attention_pkg.sv
// Shared helpers for the attention-stage buffers.
//   ptr_width : index width for a power-of-two buffer depth
//   occ_mod   : modular occupancy (write minus read pointer) over a cnt_w-bit pointer space
//   max3      : largest of three occupancies
package attention_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned occ_mod(input int unsigned wp, input int unsigned rp,
                                            input int unsigned cnt_w);
        int unsigned mask;
        mask = (32'd1 << cnt_w) - 32'd1;
        return (wp - rp) & mask;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fixed_att_fork_branch.sv
// One read branch of the broadcast buffer: owns its read pointer.
//   clk, rst   : clock, async active-low reset
//   i_wp       : shared write pointer (with wrap bit)
//   i_ready    : consumer accepts the head word
//   o_valid    : branch has an unread word
//   o_rp       : read pointer (with wrap bit), used by the top to select the head word
//   o_occ      : words written but not yet read on this branch
module fixed_att_fork_branch
    import attention_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_wp,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_rp,
    output logic [CNT_W-1:0] o_occ
);

    logic [CNT_W-1:0] r_rp;
    logic             w_pop;

    assign o_valid = (i_wp != r_rp);
    assign w_pop   = o_valid && i_ready;
    assign o_rp    = r_rp;
    assign o_occ   = CNT_W'(occ_mod(32'(i_wp), 32'(r_rp), CNT_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rp <= '0;
        end else if (w_pop) begin
            r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/fixed_att_input_fork.sv
// Registered three-way broadcast buffer feeding the Q, K and V inputs of the attention block.
// One shared storage array and write pointer; each branch reads at its own pace and a slot is
// reused only after the slowest branch has read it.
//   clk, rst                         : clock, async active-low reset
//   data_in, data_in_valid/ready     : upstream block stream
//   data_out_{q,k,v}, *_valid/ready  : per-branch head word and handshake
module fixed_att_input_fork
    import attention_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned IN_PARALLELISM = 3,
    parameter int unsigned IN_SIZE        = 3,
    parameter int unsigned DEPTH          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_PARALLELISM*IN_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_q [IN_PARALLELISM*IN_SIZE],
    output logic [DATA_WIDTH-1:0] data_out_k [IN_PARALLELISM*IN_SIZE],
    output logic [DATA_WIDTH-1:0] data_out_v [IN_PARALLELISM*IN_SIZE],
    output logic                  data_out_q_valid,
    output logic                  data_out_k_valid,
    output logic                  data_out_v_valid,
    input  logic                  data_out_q_ready,
    input  logic                  data_out_k_ready,
    input  logic                  data_out_v_ready
);

    localparam int unsigned NumElem = IN_PARALLELISM * IN_SIZE;
    localparam int unsigned WordW   = NumElem * DATA_WIDTH;
    localparam int unsigned PtrW    = ptr_width(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;

    logic [WordW-1:0] r_mem [DEPTH];
    logic [CntW-1:0]  r_wp;

    logic [WordW-1:0] w_din;
    logic             w_push;
    logic [CntW-1:0]  w_rp_q, w_rp_k, w_rp_v;
    logic [CntW-1:0]  w_occ_q, w_occ_k, w_occ_v;
    int unsigned      w_used;

    // Storage is kept as packed words; ports are element arrays.
    for (genvar g = 0; g < NumElem; g++) begin : g_elem
        assign w_din[g*DATA_WIDTH +: DATA_WIDTH] = data_in[g];
        assign data_out_q[g] = r_mem[w_rp_q[PtrW-1:0]][g*DATA_WIDTH +: DATA_WIDTH];
        assign data_out_k[g] = r_mem[w_rp_k[PtrW-1:0]][g*DATA_WIDTH +: DATA_WIDTH];
        assign data_out_v[g] = r_mem[w_rp_v[PtrW-1:0]][g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Ready looks only at registered pointers: a pop this cycle frees its slot next cycle.
    assign w_used        = max3(32'(w_occ_q), 32'(w_occ_k), 32'(w_occ_v));
    assign data_in_ready = (w_used < DEPTH) && rst;
    assign w_push        = data_in_valid && data_in_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[PtrW-1:0]] <= w_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
        end else if (w_push) begin
            r_wp <= r_wp + 1'b1;
        end
    end

    fixed_att_fork_branch #(
        .CNT_W (CntW)
    ) u_branch_q (
        .clk     (clk),
        .rst     (rst),
        .i_wp    (r_wp),
        .i_ready (data_out_q_ready),
        .o_valid (data_out_q_valid),
        .o_rp    (w_rp_q),
        .o_occ   (w_occ_q)
    );

    fixed_att_fork_branch #(
        .CNT_W (CntW)
    ) u_branch_k (
        .clk     (clk),
        .rst     (rst),
        .i_wp    (r_wp),
        .i_ready (data_out_k_ready),
        .o_valid (data_out_k_valid),
        .o_rp    (w_rp_k),
        .o_occ   (w_occ_k)
    );

    fixed_att_fork_branch #(
        .CNT_W (CntW)
    ) u_branch_v (
        .clk     (clk),
        .rst     (rst),
        .i_wp    (r_wp),
        .i_ready (data_out_v_ready),
        .o_valid (data_out_v_valid),
        .o_rp    (w_rp_v),
        .o_occ   (w_occ_v)
    );

endmodule

// File: tb/tb_fixed_att_input_fork.sv
// Self-checking bench for fixed_att_input_fork. Reference: one FIFO queue per branch; a push
// appends to all three, a pop removes from one, ready = fewer than DEPTH words on every branch.
module tb_fixed_att_input_fork;

    localparam int unsigned DW    = 8;
    localparam int unsigned NE    = 9;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned W     = DW * NE;

    typedef logic [W-1:0] word_t;

    logic          clk;
    logic          rst;
    logic          din_valid;
    word_t         din_word;
    logic          rq, rk, rv;
    logic [DW-1:0] data_in    [NE];
    logic [DW-1:0] data_out_q [NE];
    logic [DW-1:0] data_out_k [NE];
    logic [DW-1:0] data_out_v [NE];
    logic          data_in_ready;
    logic          vq, vk, vv;
    word_t         out_q, out_k, out_v;

    for (genvar g = 0; g < NE; g++) begin : g_pack
        assign data_in[g]          = din_word[g*DW +: DW];
        assign out_q[g*DW +: DW]   = data_out_q[g];
        assign out_k[g*DW +: DW]   = data_out_k[g];
        assign out_v[g*DW +: DW]   = data_out_v[g];
    end

    fixed_att_input_fork #(
        .DATA_WIDTH     (DW),
        .IN_PARALLELISM (3),
        .IN_SIZE        (3),
        .DEPTH          (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .data_in_valid    (din_valid),
        .data_in_ready    (data_in_ready),
        .data_out_q       (data_out_q),
        .data_out_k       (data_out_k),
        .data_out_v       (data_out_v),
        .data_out_q_valid (vq),
        .data_out_k_valid (vk),
        .data_out_v_valid (vv),
        .data_out_q_ready (rq),
        .data_out_k_ready (rk),
        .data_out_v_ready (rv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model
    word_t mq_q[$];
    word_t mq_k[$];
    word_t mq_v[$];
    bit    m_rst = 1'b0;

    // Observed values, captured on the falling edge
    logic       o_ready;
    logic [2:0] o_valid;
    word_t      o_data [3];

    function automatic int msize(input int b);
        case (b)
            0:       return mq_q.size();
            1:       return mq_k.size();
            default: return mq_v.size();
        endcase
    endfunction

    function automatic bit exp_valid(input int b);
        return msize(b) > 0;
    endfunction

    function automatic word_t exp_head(input int b);
        case (b)
            0:       return mq_q[0];
            1:       return mq_k[0];
            default: return mq_v[0];
        endcase
    endfunction

    function automatic bit exp_ready();
        int m;
        m = msize(0);
        if (msize(1) > m) m = msize(1);
        if (msize(2) > m) m = msize(2);
        return m_rst && (m < int'(DEPTH));
    endfunction

    function automatic word_t fill(input logic [7:0] b);
        return {NE{b}};
    endfunction

    task automatic model_clear();
        mq_q.delete();
        mq_k.delete();
        mq_v.delete();
    endtask

    task automatic sample();
        @(negedge clk);
        o_ready   = data_in_ready;
        o_valid   = {vv, vk, vq};
        o_data[0] = out_q;
        o_data[1] = out_k;
        o_data[2] = out_v;
    endtask

    // Apply this cycle's predicted handshakes to the model at the rising edge.
    task automatic advance(output bit pushed);
        bit p;
        bit pq, pk, pv;
        p  = din_valid && exp_ready();
        pq = rq && exp_valid(0);
        pk = rk && exp_valid(1);
        pv = rv && exp_valid(2);
        @(posedge clk);
        #1;
        if (pq) void'(mq_q.pop_front());
        if (pk) void'(mq_k.pop_front());
        if (pv) void'(mq_v.pop_front());
        if (p) begin
            mq_q.push_back(din_word);
            mq_k.push_back(din_word);
            mq_v.push_back(din_word);
        end
        pushed = p;
    endtask

    task automatic test_reset();
        bit p;
        rst = 1'b0; m_rst = 1'b0;
        din_valid = 1'b1; din_word = fill(8'h33);
        rq = 1'b1; rk = 1'b1; rv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            n_tests++;
            if (o_ready !== 1'b0 || o_valid !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: ready=%b valids=%b want 0/000", c, o_ready, o_valid);
            end
            advance(p);
        end
        rst = 1'b1; m_rst = 1'b1; din_valid = 1'b0;
        sample();
        n_tests++;
        if (o_ready !== 1'b1 || o_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valids=%b want 1/000", o_ready, o_valid);
        end
        advance(p);
    endtask

    task automatic test_single();
        bit p;
        din_valid = 1'b1; din_word = fill(8'h11);
        rq = 1'b1; rk = 1'b0; rv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) din_valid = 1'b0;
            if (c == 3) begin rk = 1'b1; rv = 1'b1; end
            sample();
            n_tests++;
            if (o_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL single ready cyc%0d: got %b want %b", c, o_ready, exp_ready());
            end
            for (int b = 0; b < 3; b++) begin
                n_tests++;
                if (o_valid[b] !== exp_valid(b)) begin
                    n_fail++;
                    $display("FAIL single valid[%0d] cyc%0d: got %b want %b", b, c, o_valid[b], exp_valid(b));
                end else if (exp_valid(b) && o_data[b] !== exp_head(b)) begin
                    n_fail++;
                    $display("FAIL single data[%0d] cyc%0d: got %h want %h", b, c, o_data[b], exp_head(b));
                end
            end
            // After q takes the word, k and v still hold 0x11 and the buffer is not full.
            if (c == 2) begin
                n_tests++;
                if (o_valid !== 3'b110 || o_data[1] !== fill(8'h11) || o_data[2] !== fill(8'h11)
                    || o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_kv_hold: valids=%b k=%h v=%h ready=%b want 110/11../11../1",
                             o_valid, o_data[1], o_data[2], o_ready);
                end
            end
            advance(p);
        end
    endtask

    task automatic test_backpressure();
        bit p;
        int k;
        rq = 1'b0; rk = 1'b0; rv = 1'b0;
        k = 0;
        din_valid = 1'b1; din_word = fill(8'hA0);
        for (int c = 0; c < 14; c++) begin
            if (c == 5) begin rq = 1'b1; rk = 1'b1; end
            if (c == 7) rv = 1'b1;
            din_word = fill(8'(8'hA0 + k));
            if (k > 2) din_valid = 1'b0;
            sample();
            n_tests++;
            if (o_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL backpressure ready cyc%0d: got %b want %b", c, o_ready, exp_ready());
            end
            for (int b = 0; b < 3; b++) begin
                n_tests++;
                if (o_valid[b] !== exp_valid(b)) begin
                    n_fail++;
                    $display("FAIL backpressure valid[%0d] cyc%0d: got %b want %b", b, c, o_valid[b], exp_valid(b));
                end else if (exp_valid(b) && o_data[b] !== exp_head(b)) begin
                    n_fail++;
                    $display("FAIL backpressure data[%0d] cyc%0d: got %h want %h", b, c, o_data[b], exp_head(b));
                end
            end
            // Two words in, nobody reading, and q/k draining alone must not open the input.
            if (c >= 2 && c <= 7) begin
                n_tests++;
                if (o_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_full cyc%0d: ready got %b want 0", c, o_ready);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_release: ready got %b want 1", o_ready);
                end
            end
            advance(p);
            if (p) k++;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_streaming();
        bit p;
        int k;
        rq = 1'b1; rk = 1'b1; rv = 1'b1;
        k = 0;
        for (int c = 0; c < 19; c++) begin
            din_valid = (k < 16);
            din_word  = fill(8'(k));
            sample();
            n_tests++;
            if (o_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL streaming ready cyc%0d: got %b want %b", c, o_ready, exp_ready());
            end
            for (int b = 0; b < 3; b++) begin
                n_tests++;
                if (o_valid[b] !== exp_valid(b)) begin
                    n_fail++;
                    $display("FAIL streaming valid[%0d] cyc%0d: got %b want %b", b, c, o_valid[b], exp_valid(b));
                end else if (exp_valid(b) && o_data[b] !== exp_head(b)) begin
                    n_fail++;
                    $display("FAIL streaming data[%0d] cyc%0d: got %h want %h", b, c, o_data[b], exp_head(b));
                end
            end
            // No bubbles: word c-1 must be at every head on cycle c.
            if (c >= 1 && c <= 16) begin
                n_tests++;
                if (o_valid !== 3'b111 || o_data[0] !== fill(8'(c - 1)) || o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL streaming_rate cyc%0d: valids=%b q=%h ready=%b want 111/%h/1",
                             c, o_valid, o_data[0], o_ready, fill(8'(c - 1)));
                end
            end
            advance(p);
            if (p) k++;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_skew_wrap();
        bit p;
        int k;
        int npop [3];
        int c;
        k = 0; c = 0;
        npop[0] = 0; npop[1] = 0; npop[2] = 0;
        rq = 1'b1; rv = 1'b1;
        while ((k < 100 || msize(0) + msize(1) + msize(2) > 0) && c < 2000) begin
            rk        = ($urandom_range(0, 2) == 0);
            din_valid = (k < 100);
            din_word  = {$urandom(), $urandom(), 8'(k)};
            sample();
            n_tests++;
            if (o_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL skew ready cyc%0d: got %b want %b", c, o_ready, exp_ready());
            end
            for (int b = 0; b < 3; b++) begin
                n_tests++;
                if (o_valid[b] !== exp_valid(b)) begin
                    n_fail++;
                    $display("FAIL skew valid[%0d] cyc%0d: got %b want %b", b, c, o_valid[b], exp_valid(b));
                end else if (exp_valid(b) && o_data[b] !== exp_head(b)) begin
                    n_fail++;
                    $display("FAIL skew data[%0d] cyc%0d: got %h want %h", b, c, o_data[b], exp_head(b));
                end
            end
            if (o_valid[0] === 1'b1 && rq) npop[0]++;
            if (o_valid[1] === 1'b1 && rk) npop[1]++;
            if (o_valid[2] === 1'b1 && rv) npop[2]++;
            advance(p);
            if (p) k++;
            c++;
        end
        n_tests++;
        if (c >= 2000) begin
            n_fail++;
            $display("FAIL skew_timeout: pushed %0d of 100 within 2000 cycles", k);
        end
        for (int b = 0; b < 3; b++) begin
            n_tests++;
            if (npop[b] != 100) begin
                n_fail++;
                $display("FAIL skew_count[%0d]: got %0d pops want 100", b, npop[b]);
            end
        end
        din_valid = 1'b0; rk = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit p;
        rq = 1'b1; rk = 1'b1; rv = 1'b0;
        din_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            din_word = fill(8'(8'h60 + c));
            advance(p);
        end
        din_valid = 1'b0;
        advance(p);
        #2;
        rst = 1'b0; m_rst = 1'b0;
        model_clear();
        sample();
        n_tests++;
        if (o_valid !== 3'b000 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: valids=%b ready=%b want 000/0", o_valid, o_ready);
        end
        advance(p);
        rst = 1'b1; m_rst = 1'b1;
        rq = 1'b0; rk = 1'b0; rv = 1'b0;
        din_valid = 1'b1; din_word = fill(8'h55);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) din_valid = 1'b0;
            if (c == 2) begin rq = 1'b1; rk = 1'b1; rv = 1'b1; end
            sample();
            n_tests++;
            if (o_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL reset_mid ready cyc%0d: got %b want %b", c, o_ready, exp_ready());
            end
            for (int b = 0; b < 3; b++) begin
                n_tests++;
                if (o_valid[b] !== exp_valid(b)) begin
                    n_fail++;
                    $display("FAIL reset_mid valid[%0d] cyc%0d: got %b want %b", b, c, o_valid[b], exp_valid(b));
                end else if (exp_valid(b) && o_data[b] !== exp_head(b)) begin
                    n_fail++;
                    $display("FAIL reset_mid data[%0d] cyc%0d: got %h want %h", b, c, o_data[b], exp_head(b));
                end
            end
            if (c == 1) begin
                n_tests++;
                if (o_valid !== 3'b111 || o_data[2] !== fill(8'h55)) begin
                    n_fail++;
                    $display("FAIL reset_mid_fresh: valids=%b v=%h want 111/%h", o_valid, o_data[2], fill(8'h55));
                end
            end
            advance(p);
        end
    endtask

    initial begin
        rst = 1'b0; din_valid = 1'b0; din_word = '0;
        rq = 1'b0; rk = 1'b0; rv = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_skew_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
